// File: rtl/triple_repeat_serializer_if.sv
// Handshake and serial-output bundle for triple_repeat_serializer.
// master: word producer / frame consumer side. slave: the serializer.
interface triple_repeat_serializer_if #(
  parameter int NBITS = 8
);
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_data;
  logic             out_val;
  logic             out_bit;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_val, in_data,
    input  in_rdy, out_val, out_bit, out_first, out_last
  );

  modport slave (
    input  in_val, in_data,
    output in_rdy, out_val, out_bit, out_first, out_last
  );
endinterface

// File: rtl/triple_repeat_serializer.sv
// Repetition-coded serializer: each word is sent LSB first, every bit held
// for 3 cycles so a majority-of-3 receiver can vote it back.
// Optional macro TRIPLE_REPEAT_SERIALIZER_PARITY_EN appends an even-parity
// symbol (also repeated 3 times) after the MSB.
// All outputs decode registered state only; in_val/in_data never reach them.
module triple_repeat_serializer #(
  parameter int NBITS = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  triple_repeat_serializer_if.slave   bus
);

`ifdef TRIPLE_REPEAT_SERIALIZER_PARITY_EN
  localparam int NSYM = NBITS + 1;
`else
  localparam int NSYM = NBITS;
`endif
  localparam int             IW       = $clog2(NBITS + 2);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NSYM - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rep_q, rep_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NSYM-1:0]   sh_q, sh_d;
  logic              en_q;
  logic [NSYM-1:0]   load_w;
  logic              send, last_c, rdy, acc;

  // Word as loaded into the shift register (parity rides above the MSB).
`ifdef TRIPLE_REPEAT_SERIALIZER_PARITY_EN
  assign load_w = {^bus.in_data, bus.in_data};
`else
  assign load_w = bus.in_data;
`endif

  assign send   = (state_q == SEND);
  assign last_c = send && (rep_q == 2'd2) && (idx_q == LAST_IDX);
  // en_q masks ready through reset and the first edge after release.
  assign rdy    = en_q && (!send || last_c);
  assign acc    = bus.in_val && rdy;

  assign bus.in_rdy    = rdy;
  assign bus.out_val   = send;
  assign bus.out_bit   = send && sh_q[0];
  assign bus.out_first = send && (rep_q == 2'd0) && (idx_q == '0);
  assign bus.out_last  = last_c;

  // State, counters and shift register; async clear aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rep_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      en_q    <= 1'b1;
    end
  end

  // Next state: 3 cycles per symbol, shift on the third, reload on accept.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = SEND;
          rep_d   = '0;
          idx_d   = '0;
          sh_d    = load_w;
        end
      end
      SEND: begin
        if (rep_q == 2'd2) begin
          rep_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (acc) begin
              sh_d = load_w;
            end else begin
              state_d = IDLE;
              sh_d    = '0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            sh_d  = sh_q >> 1;
          end
        end else begin
          rep_d = rep_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/triple_repeat_serializer.md
TRIPLE_REPEAT_SERIALIZER -- requirements
Module: triple_repeat_serializer

Interface
REQ-001: Parameter NBITS, default 8, SHALL set the data word width; legal range 2..16.
REQ-002: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: in_val  input  1  upstream word valid.
REQ-005: in_rdy  output  1  serializer can accept a word this cycle.
REQ-006: in_data  input  NBITS  word to transmit.
REQ-007: out_val  output  1  out_bit is carrying a frame bit this cycle.
REQ-008: out_bit  output  1  serial repetition-coded bit, for a majority-of-3 receiver.
REQ-009: out_first  output  1  high on the first cycle of each frame only.
REQ-010: out_last  output  1  high on the final cycle of each frame only.

Function
REQ-011: The block SHALL accept a word on any rising edge where in_val and in_rdy are both 1, capturing in_data into an internal shift register.
REQ-012: The frame SHALL begin the cycle after acceptance, giving one cycle of latency to the first out_val.
REQ-013: The block SHALL send data bits LSB first, and each bit SHALL appear on out_bit for exactly 3 consecutive cycles with out_val = 1.
REQ-014: The frame length SHALL be 3*NBITS cycles, or 3*(NBITS+1) cycles with parity (REQ-025).
REQ-015: The FSM SHALL have two states.
- IDLE: out_val=0, out_bit=0, in_rdy=1.
- SEND: out_val=1.
REQ-016: The FSM SHALL use these transitions.
- IDLE->SEND on accept.
- SEND->IDLE on the out_last cycle when no accept occurs.
- SEND->SEND on the out_last cycle when an accept occurs.
REQ-017: in_rdy SHALL be 1 in IDLE and on the out_last cycle of SEND, and 0 on all other SEND cycles.
- This allows back-to-back frames with no idle gap.
REQ-018: On a back-to-back accept, out_first of the new frame SHALL occur on the cycle immediately after out_last.
REQ-019: Counters SHALL be sized as follows.
- Repeat counter: 2 bits, counting 0..2 and wrapping to 0.
- Bit index: ceil(log2(NBITS+2)) bits.
- Neither counter SHALL reach an unused value.
REQ-020: in_data SHALL be ignored when no accept occurs, and changes to in_data mid-frame SHALL NOT affect the frame in progress.
REQ-021: When NBITS=2 without parity, the frame SHALL be 6 cycles, and out_first and out_last SHALL never coincide.
REQ-022: out_bit, out_val, out_first, out_last and in_rdy SHALL be driven from registered state, with no combinational path from in_val or in_data to the outputs.

Reset
REQ-023: Assertion of rst_n=0 SHALL immediately, without waiting for clk, force the following values, aborting any frame in progress.
- FSM to IDLE; counters and shift register to 0.
- out_val=0, out_bit=0, out_first=0, out_last=0.
REQ-024: While rst_n=0, in_rdy SHALL be 0, and no accept SHALL occur on the first rising edge after deassertion.
- in_rdy SHALL become 1 after that edge.

Configuration
REQ-025: Macro TRIPLE_REPEAT_SERIALIZER_PARITY_EN SHALL control parity.
- Defined: after the MSB, the block SHALL send one even-parity bit (XOR of all NBITS data bits), also repeated 3 times, so out_last falls on the final parity cycle.
- Undefined: no parity logic SHALL exist, and the frame SHALL end on the final MSB cycle.

Verification
REQ-026: Reset, then in_data=8'hA5 accepted at cycle 1 (macro undefined) -> cycles 2..25 give out_bit=1,1,1,0,0,0,1,1,1,0,0,0,0,0,0,1,1,1,0,0,0,1,1,1.
- out_first at cycle 2, out_last at cycle 25, in_rdy=0 on cycles 2..24.
REQ-027: 8'h01 then 8'hFF with in_val held high -> 8'hFF is accepted on the 8'h01 out_last cycle.
- The next cycle shows out_first with out_bit=1, and there are no out_val=0 gaps.
REQ-028: rst_n pulled low mid-edge-interval at frame cycle 10 of 8'h3C -> out_val and out_bit read 0 before the next clk edge.
- After release, in_rdy=0 for one edge, then 1, and a new word 8'h81 is sent correctly.
REQ-029: Macro defined, 8'h07 -> 27-cycle frame whose final 3 cycles give out_bit=1 (odd weight); 8'h03 -> final 3 cycles give out_bit=0.
REQ-030: in_val=0 for 20 cycles after reset, and in_data toggling mid-frame during an 8'hC3 frame -> out_val stays 0 while idle, and the frame bits match 8'hC3 only.
